// File: rtl/jk_cmd_sequencer_pkg.sv
// Shared definitions for the JK command sequencer: command encodings, FSM state
// encoding, FIFO entry layout and the repeat-count load helper.
package jk_seq_pkg;

   localparam int unsigned CNT_W = 8;

   localparam logic [1:0] CMD_HOLD = 2'b00;
   localparam logic [1:0] CMD_RST  = 2'b01;
   localparam logic [1:0] CMD_SET  = 2'b10;
   localparam logic [1:0] CMD_TGL  = 2'b11;

   typedef enum logic {
      IDLE  = 1'b0,
      DRIVE = 1'b1
   } state_e;

   typedef struct packed {
      logic [1:0]       cmd;
      logic [CNT_W-1:0] rep;
   } fifo_entry_t;

   localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

   // A repeat count of zero still drives the command for one cycle.
   function automatic logic [CNT_W-1:0] rep_load(input logic [CNT_W-1:0] rep);
      return (rep == '0) ? CNT_W'(1) : rep;
   endfunction

endpackage

// File: rtl/jk_cmd_sequencer_if.sv
// Command/drive bundle between the command source, the sequencer and the JK
// flip-flop feedback.
//   cmd_valid/cmd_ready/cmd/cmd_rep : command handshake
//   j/k                             : flip-flop drive
//   busy/done                       : status
//   q_fb/q_exp/mismatch             : flip-flop feedback and shadow check
interface jk_cmd_sequencer_if;
   import jk_seq_pkg::*;

   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd;
   logic [CNT_W-1:0] cmd_rep;
   logic             j;
   logic             k;
   logic             busy;
   logic             done;
   logic             q_fb;
   logic             q_exp;
   logic             mismatch;

   modport master (
      output cmd_valid, cmd, cmd_rep, q_fb,
      input  cmd_ready, j, k, busy, done, q_exp, mismatch
   );

   modport slave (
      input  cmd_valid, cmd, cmd_rep, q_fb,
      output cmd_ready, j, k, busy, done, q_exp, mismatch
   );

endinterface

// File: rtl/jk_cmd_sequencer_fifo.sv
// jk_cmd_fifo: synchronous FIFO with show-ahead read data.
//   clk, rst_n   : clock, async active-low reset
//   push_i/data_i: write request (ignored when full)
//   pop_i/data_o : read request (ignored when empty), head entry
//   full_o/empty_o/count_o : occupancy
module jk_cmd_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       data_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Storage array carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: buffers JK commands and drives J/K from posedge registers so
// each level is stable around the flip-flop's falling-edge sample.
//   clk, rst_n : clock, async active-low reset
//   bus (slave): command handshake, J/K drive, busy/done, Q feedback/shadow
// Optional feature macro: JK_SHADOW_CHECK_EN (shadow Q model and MISMATCH flag).
module jk_cmd_sequencer
   import jk_seq_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   jk_cmd_sequencer_if.slave bus
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   state_e           state_q, state_d;
   logic             j_q, j_d, k_q, k_d, done_q, done_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pop;
   logic             push;
   logic             fifo_full, fifo_empty;
   logic [CW-1:0]    fifo_count;
   fifo_entry_t      push_entry, head;

   assign push_entry = '{cmd: bus.cmd, rep: bus.cmd_rep};
   assign push       = bus.cmd_valid && !fifo_full;

   jk_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .data_i  (push_entry),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and pop: a new command loads from IDLE or back-to-back on the last DRIVE cycle.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = DRIVE;
            end
         end
         DRIVE: begin
            if (cnt_q == CNT_W'(1)) begin
               if (!fifo_empty) pop     = 1'b1;
               else             state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output next values; DONE is registered so it lines up with the final DRIVE cycle.
   always_comb begin
      j_d   = j_q;
      k_d   = k_q;
      cnt_d = cnt_q;
      if (pop) begin
         j_d   = head.cmd[1];
         k_d   = head.cmd[0];
         cnt_d = rep_load(head.rep);
      end else if (state_d == IDLE) begin
         j_d   = 1'b0;
         k_d   = 1'b0;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q - CNT_W'(1);
      end
      done_d = (state_d == DRIVE) && (cnt_d == CNT_W'(1));
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         j_q    <= 1'b0;
         k_q    <= 1'b0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         j_q    <= j_d;
         k_q    <= k_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign bus.j         = j_q;
   assign bus.k         = k_q;
   assign bus.done      = done_q;
   assign bus.busy      = (state_q != IDLE) || !fifo_empty;
   assign bus.cmd_ready = (fifo_count < CW'(DEPTH));

`ifdef JK_SHADOW_CHECK_EN
   logic q_exp_q, q_exp_d, armed_q, armed_d, mismatch_q, mismatch_d;
   logic q_model;

   // Shadow flip-flop: tracks Q_FB until a reset command pins a known state, then predicts.
   always_comb begin
      q_model    = (state_q == DRIVE) ? ((j_q & ~q_exp_q) | (~k_q & q_exp_q)) : q_exp_q;
      q_exp_d    = q_model;
      armed_d    = armed_q;
      mismatch_d = mismatch_q;
      if (!armed_q) begin
         if ((state_q == DRIVE) && ({j_q, k_q} == CMD_RST)) begin
            armed_d = 1'b1;
            q_exp_d = 1'b0;
         end else begin
            q_exp_d = bus.q_fb;
         end
      end else if (bus.q_fb != q_model) begin
         mismatch_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_exp_q    <= 1'b0;
         armed_q    <= 1'b0;
         mismatch_q <= 1'b0;
      end else begin
         q_exp_q    <= q_exp_d;
         armed_q    <= armed_d;
         mismatch_q <= mismatch_d;
      end
   end

   assign bus.q_exp    = q_exp_q;
   assign bus.mismatch = mismatch_q;
`else
   logic unused_q_fb;
   assign unused_q_fb  = bus.q_fb;
   assign bus.q_exp    = 1'b0;
   assign bus.mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Self-checking bench for jk_cmd_sequencer: a directed vector table, a queue-based
// reference model for randomized traffic, and hand-written corner sequences.
module tb_jk_cmd_sequencer;
   import jk_seq_pkg::*;

   localparam int unsigned DEPTH = 4;
`ifdef JK_SHADOW_CHECK_EN
   localparam bit SHADOW = 1'b1;
`else
   localparam bit SHADOW = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   jk_cmd_sequencer_if bus();

   jk_cmd_sequencer #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Downstream flip-flop: samples J/K on the falling edge, never reset.
   logic q_ff = 1'b0;
   bit   force_low = 1'b0;
   always @(negedge clk) q_ff <= (bus.j & ~q_ff) | (~bus.k & q_ff);
   assign bus.q_fb = force_low ? 1'b0 : q_ff;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: queue of buffered commands plus the command being driven.
   typedef struct packed {
      logic [1:0]       cmd;
      logic [CNT_W-1:0] rep;
   } mcmd_t;

   mcmd_t      pend[$];
   logic [1:0] act_cmd = 2'b00;
   int         act_left = 0;

   task automatic model_reset();
      pend.delete();
      act_cmd  = 2'b00;
      act_left = 0;
   endtask

   // One posedge: finish a drive cycle, start the next buffered command, then accept.
   task automatic model_edge(input logic v, input logic [1:0] c, input logic [CNT_W-1:0] r,
                             output bit acc);
      mcmd_t e;
      acc = v && (pend.size() < DEPTH);
      if (act_left > 0) act_left--;
      if (act_left == 0 && pend.size() > 0) begin
         e        = pend.pop_front();
         act_cmd  = e.cmd;
         act_left = (e.rep == '0) ? 1 : int'(e.rep);
      end
      if (acc) pend.push_back('{cmd: c, rep: r});
   endtask

   task automatic compare_all(input bit chk_sh);
      chk("j",     bus.j,         (act_left > 0) ? 32'(act_cmd[1]) : 32'd0);
      chk("k",     bus.k,         (act_left > 0) ? 32'(act_cmd[0]) : 32'd0);
      chk("done",  bus.done,      32'(act_left == 1));
      chk("busy",  bus.busy,      32'((act_left > 0) || (pend.size() > 0)));
      chk("ready", bus.cmd_ready, 32'(pend.size() < DEPTH));
      if (chk_sh) begin
         chk("q_exp",    bus.q_exp,    SHADOW ? 32'(q_ff) : 32'd0);
         chk("mismatch", bus.mismatch, 32'd0);
      end
   endtask

   task automatic cycle(input logic v, input logic [1:0] c, input logic [CNT_W-1:0] r,
                        input bit chk_sh, output bit acc);
      bus.cmd_valid = v;
      bus.cmd       = c;
      bus.cmd_rep   = r;
      @(posedge clk);
      model_edge(v, c, r, acc);
      #1;
      compare_all(chk_sh);
   endtask

   typedef struct {
      logic             v;
      logic [1:0]       c;
      logic [CNT_W-1:0] r;
      logic             j, k, done, busy, ready, qexp;
   } vec_t;

   vec_t tbl[9];

   logic [1:0]       bp_cmd[6];
   logic [CNT_W-1:0] bp_rep[6];

   initial begin
      bit               acc;
      logic             v;
      logic [1:0]       c;
      logic [CNT_W-1:0] r;
      int               idx, dut_acc;

      bus.cmd_valid = 1'b0;
      bus.cmd       = 2'b00;
      bus.cmd_rep   = '0;

      // Reset, then {01,1},{11,3},{00,2} back-to-back from an unarmed start.
      tbl[0] = '{1'b1, CMD_RST,  8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[1] = '{1'b1, CMD_TGL,  8'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[2] = '{1'b1, CMD_HOLD, 8'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[3] = '{1'b0, CMD_HOLD, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[4] = '{1'b0, CMD_HOLD, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[5] = '{1'b0, CMD_HOLD, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[6] = '{1'b0, CMD_HOLD, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[7] = '{1'b0, CMD_HOLD, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[8] = '{1'b0, CMD_HOLD, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

      bp_cmd = '{CMD_RST, CMD_SET, CMD_HOLD, CMD_TGL, CMD_SET, CMD_RST};
      bp_rep = '{8'd2, 8'd1, 8'd3, 8'd2, 8'd4, 8'd1};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready",    bus.cmd_ready, 1);
      chk("rst_j",        bus.j,         0);
      chk("rst_k",        bus.k,         0);
      chk("rst_busy",     bus.busy,      0);
      chk("rst_done",     bus.done,      0);
      chk("rst_q_exp",    bus.q_exp,     0);
      chk("rst_mismatch", bus.mismatch,  0);
      rst_n = 1'b1;
      model_reset();

      for (int i = 0; i < 9; i++) begin
         bus.cmd_valid = tbl[i].v;
         bus.cmd       = tbl[i].c;
         bus.cmd_rep   = tbl[i].r;
         @(posedge clk);
         model_edge(tbl[i].v, tbl[i].c, tbl[i].r, acc);
         #1;
         chk($sformatf("tbl%0d_j", i),     bus.j,         tbl[i].j);
         chk($sformatf("tbl%0d_k", i),     bus.k,         tbl[i].k);
         chk($sformatf("tbl%0d_done", i),  bus.done,      tbl[i].done);
         chk($sformatf("tbl%0d_busy", i),  bus.busy,      tbl[i].busy);
         chk($sformatf("tbl%0d_ready", i), bus.cmd_ready, tbl[i].ready);
         chk($sformatf("tbl%0d_q_exp", i), bus.q_exp,     SHADOW ? 32'(tbl[i].qexp) : 32'd0);
         chk($sformatf("tbl%0d_mm", i),    bus.mismatch,  0);
      end

      // Single set command, REP=1.
      cycle(1'b1, CMD_SET, 8'd1, 1'b1, acc);
      repeat (3) cycle(1'b0, CMD_HOLD, 8'd0, 1'b1, acc);

      // Backpressure: offer commands continuously while a long toggle runs.
      cycle(1'b1, CMD_TGL, 8'd10, 1'b1, acc);
      idx = 0;
      dut_acc = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.cmd_ready) dut_acc++;
         cycle(1'b1, bp_cmd[idx], bp_rep[idx], 1'b1, acc);
         if (acc) idx++;
      end
      chk("bp_accepted", 32'(dut_acc), 4);
      repeat (30) cycle(1'b0, CMD_HOLD, 8'd0, 1'b1, acc);

      // Randomized traffic; an unaccepted command is held until taken.
      v = 1'b0; c = 2'b00; r = '0; acc = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (!v || acc) begin
            v = ($urandom % 3) != 0;
            c = 2'($urandom);
            r = CNT_W'($urandom_range(0, 4));
         end
         cycle(v, c, r, 1'b1, acc);
      end
      repeat (30) cycle(1'b0, CMD_HOLD, 8'd0, 1'b1, acc);

      // Arm, then hold Q_FB low during a set command.
      cycle(1'b1, CMD_RST, 8'd1, 1'b1, acc);
      repeat (3) cycle(1'b0, CMD_HOLD, 8'd0, 1'b1, acc);
      force_low = 1'b1;
      cycle(1'b1, CMD_SET, 8'd3, 1'b0, acc);
      chk("mm_push", bus.mismatch, 0);
      cycle(1'b0, CMD_HOLD, 8'd0, 1'b0, acc);
      chk("mm_pop", bus.mismatch, 0);
      cycle(1'b0, CMD_HOLD, 8'd0, 1'b0, acc);
      chk("mm_set", bus.mismatch, 32'(SHADOW));
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, CMD_HOLD, 8'd0, 1'b0, acc);
         chk($sformatf("mm_sticky%0d", i), bus.mismatch, 32'(SHADOW));
      end
      force_low = 1'b0;

      // Asynchronous reset in the middle of a {11,5} command.
      cycle(1'b1, CMD_TGL, 8'd5, 1'b0, acc);
      repeat (3) cycle(1'b0, CMD_HOLD, 8'd0, 1'b0, acc);
      chk("mid_j_pre",  bus.j,        1);
      chk("mid_mm_pre", bus.mismatch, 32'(SHADOW));
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_j",        bus.j,         0);
      chk("mid_k",        bus.k,         0);
      chk("mid_busy",     bus.busy,      0);
      chk("mid_ready",    bus.cmd_ready, 1);
      chk("mid_done",     bus.done,      0);
      chk("mid_mismatch", bus.mismatch,  0);
      chk("mid_q_exp",    bus.q_exp,     0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("post_busy", bus.busy, 0);

      // Fresh reset command re-arms; checks must keep passing afterwards.
      cycle(1'b1, CMD_RST, 8'd1, 1'b1, acc);
      v = 1'b0; acc = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (!v || acc) begin
            v = ($urandom % 2) != 0;
            c = 2'($urandom);
            r = CNT_W'($urandom_range(0, 3));
         end
         cycle(v, c, r, 1'b1, acc);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/jk_cmd_sequencer.md
# jk_cmd_sequencer

Upstream drive stage for the negedge-sampled JK flip-flop. Accepts JK commands (hold/reset/set/toggle plus repeat count) over a valid/ready handshake, buffers them in a small FIFO, and drives J/K from posedge-registered outputs, so each value is stable for a full cycle around the flip-flop's falling-edge sample. Optionally keeps a shadow model of Q and flags divergence from the fed-back flip-flop output.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- CNT_W, 8, repeat-count width
- CLK  in  1  clock; all block state updates on posedge
- RST_N  in  1  asynchronous, active-low reset
- CMD_VALID  in  1  command offered
- CMD_READY  out  1  FIFO not full
- CMD  in  2  {J,K}: 00 hold, 01 reset, 10 set, 11 toggle
- CMD_REP  in  CNT_W  falling edges to apply; 0 treated as 1
- J  out  1  to flip-flop J
- K  out  1  to flip-flop K
- BUSY  out  1  state != IDLE or FIFO non-empty
- DONE  out  1  one-cycle pulse, command finished
- Q_FB  in  1  flip-flop Q fed back
- Q_EXP  out  1  shadow Q
- MISMATCH  out  1  sticky Q_FB vs shadow disagreement

## Operation
- Reset values: CMD_READY=1, J=0, K=0, BUSY=0, DONE=0, Q_EXP=0, MISMATCH=0. FIFO empty, state IDLE, counter 0, armed=0.
- Push on posedge with CMD_VALID && CMD_READY. No push when full. Push and pop in the same cycle are allowed when not full. No empty-FIFO bypass.
- FSM has two states:
  - IDLE: J=K=0. If FIFO non-empty, pop, load J/K from CMD and counter from max(CMD_REP,1), then go to DRIVE.
  - DRIVE: J/K held; counter decrements each posedge. On the posedge where counter==1:
    - DONE=1 for that cycle.
    - If FIFO non-empty, pop and load the next command back-to-back, staying in DRIVE.
    - Otherwise J=K=0 and go to IDLE.
- Shadow model updates on each posedge that ends a DRIVE cycle: Q_EXP_next = J&~Q_EXP | ~K&Q_EXP, using the J/K held during the elapsed cycle. Outside DRIVE, Q_EXP holds.
- Armed flag:
  - Cleared by reset.
  - Set at the end of the first DRIVE cycle of a 01 (reset) command; Q_EXP becomes 0 at that point.
  - While unarmed, Q_EXP loads Q_FB every posedge and no check is made.
- Check: when armed, each posedge compares Q_FB with Q_EXP_next. Inequality sets MISMATCH, which stays set until RST_N.
- Mid-operation reset clears everything immediately (async). The downstream flip-flop is not reset; the armed mechanism prevents false MISMATCH.

## Timing
- Command accepted at posedge n into an empty FIFO while IDLE:
  - popped at n+1, with J/K driven from n+1;
  - first flip-flop sample at the negedge between n+1 and n+2;
  - shadow/check at n+2.
- A command with REP=r holds J/K for exactly r cycles, giving r falling-edge samples.
- Back-to-back commands produce no idle cycle between them.
- CMD_READY is combinational from the FIFO count; it deasserts in the cycle after the push that fills the FIFO.
- DONE is asserted in the final DRIVE cycle of each command.

## Configuration
- JK_SHADOW_CHECK_EN defined: shadow model, armed flag and MISMATCH are present as described.
- JK_SHADOW_CHECK_EN undefined: Q_EXP=0 and MISMATCH=0 constantly, Q_FB is ignored, and no shadow registers are synthesized. Drive behaviour is identical in both builds.

## Structure
- Package jk_seq_pkg holds:
  - command encoding constants CMD_HOLD=2'b00, CMD_RST=2'b01, CMD_SET=2'b10, CMD_TGL=2'b11;
  - FSM state encoding (IDLE, DRIVE);
  - the FIFO entry type {cmd[1:0], rep[CNT_W-1:0]}.
- One sub-module, jk_cmd_fifo: synchronous FIFO with async active-low reset, full/empty/count outputs, parameterized by DEPTH and entry width.

## Test plan
- Reset, then push {10,REP=1} at posedge 2: J=1,K=0 during cycle 3 only; Q_FB rises at the following negedge; DONE pulses in cycle 3; Q_EXP=0 (unarmed, tracks Q_FB).
- Push {01,1}, {11,3}, {00,2} back-to-back: J/K sequence 01, 11×3, 00×2 with no gaps; Q_EXP reads 0,1,0,1 then holds 1; MISMATCH=0.
- Hold CMD_VALID for 6 cycles with the flip-flop busy on {11,10}: CMD_READY drops after the 4th stored entry; no entry is lost or duplicated; all commands execute in order.
- Armed, then force Q_FB low during a set command: MISMATCH=1 at the next posedge and stays 1 until RST_N.
- Assert RST_N low in the middle of a {11,5} command: J=K=0, BUSY=0, FIFO empty, MISMATCH=0 immediately; after release, a fresh {01,1} re-arms and checks pass.
- Build without JK_SHADOW_CHECK_EN, repeating the second scenario: identical J/K/DONE trace; Q_EXP and MISMATCH constantly 0.
